window_line_buffer: RTL and testbench
=====================================

WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, bits per channel sample; CHANNELS, default 1, channels packed per pixel; K, default 3, square kernel size (2..7); MAX_COLS, default 2048, maximum frame width; MAX_ROWS, default 2048, maximum frame height.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  clr  in  1  synchronous clear of counters and valid state, memories untouched
  cfg_cols  in  $clog2(MAX_COLS+1)  frame width in pixels
  cfg_rows  in  $clog2(MAX_ROWS+1)  frame height in pixels
  cfg_stride  in  2  window stride, legal values 1..3
  in_data  in  CHANNELS*DATA_WIDTH  raster-order pixel, channel 0 in LSBs
  in_valid  in  1  pixel offered
  in_ready  out  1  pixel accepted when in_valid && in_ready
  out_window  out  K*K*CHANNELS*DATA_WIDTH  window, element (r,c) at slice index r*K+c
  out_valid  out  1  window offered
  out_ready  in  1  window consumed when out_valid && out_ready
  frame_done  out  1  one-cycle pulse, last pixel of frame accepted

Function
REQ-003 Configuration SHALL be latched on acceptance of the first pixel of each frame (col=0,row=0); changes mid-frame SHALL be ignored.
REQ-004 Column counter SHALL increment per accepted pixel, wrap to 0 at cfg_cols-1 and then increment the row counter; row counter SHALL wrap to 0 at cfg_rows-1.
REQ-005 Block SHALL hold K-1 previous lines in line memories addressed by column; each accepted pixel SHALL shift line i into line i+1 at the same column (read-before-write).
REQ-006 A K x K shift register of columns SHALL hold the most recent K columns of the K most recent rows; row r=0 is the oldest row, c=0 the leftmost column.
REQ-007 A window SHALL be emitted for accepted pixel at (col,row) iff col>=K-1, row>=K-1, (col-(K-1)) mod stride==0, (row-(K-1)) mod stride==0.
REQ-008 Windows SHALL never span a row boundary; no padding is generated.
REQ-009 Latency SHALL be one cycle: window completed by pixel accepted at cycle t SHALL appear on out_valid at t+1.
REQ-010 Output SHALL be a single registered stage; out_window and out_valid SHALL be stable while out_valid && !out_ready.
REQ-011 in_ready SHALL equal out_ready || !out_valid; no window SHALL be dropped or duplicated.
REQ-012 out_window SHALL be zero whenever out_valid is 0.
REQ-013 frame_done SHALL pulse one cycle after acceptance of pixel (cfg_cols-1, cfg_rows-1), coincident with that pixel's window if any.
REQ-014 If cfg_cols<K or cfg_rows<K, no windows SHALL be emitted; counters and frame_done SHALL behave normally.
REQ-015 Back-to-back frames SHALL run without gaps; line contents from the previous frame SHALL never appear in a window (row gating of REQ-007 guarantees this).
REQ-016 clr SHALL take priority over a simultaneous accept: counters to 0, out_valid and frame_done to 0, accepted pixel discarded.
REQ-017 cfg_stride=0 SHALL be treated as 1.

Reset
REQ-018 On rst_n low: out_valid=0, out_window=0, frame_done=0, counters=0, shift register=0; in_ready SHALL read 1 after reset.
REQ-019 Reset mid-frame SHALL restart at pixel (0,0) of the next frame; line memory contents need not be cleared.

Structure
REQ-020 Shared package cnn_pkg SHALL hold the max-kernel constant, the stride encoding and the window slice index function.
REQ-021 Line memory SHALL be one sub-module, line_ram: simple dual-port, read-first, MAX_COLS x CHANNELS*DATA_WIDTH, instantiated K-1 times.

Verification
REQ-022 Scenarios the bench SHALL cover:
  8x8 frame, K=3, stride 1, pixel=row*8+col, out_ready=1 -> 36 windows; first window rows {0,1,2},{8,9,10},{16,17,18}; frame_done 1 cycle after pixel 63.
  Same frame, stride 2 -> 9 windows, centres at col/row 1,3,5.
  out_ready low 5 cycles after first window -> out_window held constant, in_ready=0, all 36 windows delivered in order.
  cfg_cols=2, cfg_rows=8, K=3 -> zero windows, frame_done pulses once.
  Two back-to-back 5x5 frames, K=3 -> 9 windows each, second frame's first window contains only second-frame pixels.
  rst_n low at pixel 20 of an 8x8 frame, then fresh frame -> 36 correct windows, no stale output.

Source files
------------

// File: rtl/cnn_pkg.sv
// Constants and helpers shared by the CNN streaming blocks: kernel limit,
// stride encoding and window element placement.
package cnn_pkg;

  localparam int MAX_K = 7;

  typedef logic [1:0] stride_t;
  localparam stride_t STRIDE_DEFAULT = 2'd1;

  typedef logic [$clog2(MAX_K*MAX_K)-1:0] win_idx_t;

  // A zero stride is read as stride 1.
  function automatic stride_t stride_norm(input stride_t s);
    return (s == 2'd0) ? STRIDE_DEFAULT : s;
  endfunction

  // Element (r,c) of a k x k window occupies slice r*k+c.
  function automatic win_idx_t win_slice(input int k, input int r, input int c);
    return win_idx_t'(r * k + c);
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line memory: one write port, one registered read port.
// On a same-address collision the read returns the old contents.
module line_ram #(
  parameter int DEPTH  = 2048,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    rd_data_q <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/window_line_buffer.sv
// Sliding K x K window generator over a raster pixel stream. K-1 line
// memories feed a K x K column shift register; windows leave through one register stage.
module window_line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int K          = 3,
  parameter int MAX_COLS   = 2048,
  parameter int MAX_ROWS   = 2048
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic [$clog2(MAX_COLS+1)-1:0]       cfg_cols,
  input  logic [$clog2(MAX_ROWS+1)-1:0]       cfg_rows,
  input  logic [1:0]                          cfg_stride,
  input  logic [CHANNELS*DATA_WIDTH-1:0]      in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [K*K*CHANNELS*DATA_WIDTH-1:0]  out_window,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                frame_done
);

  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int CW = $clog2(MAX_COLS + 1);
  localparam int RW = $clog2(MAX_ROWS + 1);
  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  logic [CW-1:0]      col_q, col_d, cols_q, eff_cols;
  logic [RW-1:0]      row_q, row_d, rows_q, eff_rows;
  stride_t            stride_q, eff_stride;
  stride_t            cph_q, cph_d, rph_q, rph_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [K*K*PW-1:0]  out_window_q, out_window_d, win_flat;
  logic [PW-1:0]      win_q [K][K];
  logic [PW-1:0]      win_d [K][K];
  logic [PW-1:0]      new_col [K];
  logic [PW-1:0]      line_rd [K-1];
  logic               accept, first, col_wrap, row_wrap, col_hit, row_hit, emit;

  function automatic stride_t phase_step(input stride_t ph, input stride_t s);
    return (ph == s - 2'd1) ? 2'd0 : ph + 2'd1;
  endfunction

  assign in_ready   = out_ready || !out_valid_q;
  assign accept     = in_valid && in_ready && !clr;
  // The first pixel of a frame runs on the live configuration it is about to latch.
  assign first      = (col_q == '0) && (row_q == '0);
  assign eff_cols   = first ? cfg_cols : cols_q;
  assign eff_rows   = first ? cfg_rows : rows_q;
  assign eff_stride = first ? stride_norm(cfg_stride) : stride_q;
  assign col_wrap   = (col_q == eff_cols - CW'(1));
  assign row_wrap   = (row_q == eff_rows - RW'(1));
  assign col_hit    = (col_q >= CW'(K-1)) && (cph_q == 2'd0);
  assign row_hit    = (row_q >= RW'(K-1)) && (rph_q == 2'd0);
  assign emit       = accept && col_hit && row_hit;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
      cph_d = '0;
      rph_d = '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_d = '0;
        cph_d = '0;
        if (row_wrap) begin
          row_d = '0;
          rph_d = '0;
        end else begin
          row_d = row_q + RW'(1);
          rph_d = (row_q >= RW'(K-1)) ? phase_step(rph_q, eff_stride) : 2'd0;
        end
      end else begin
        col_d = col_q + CW'(1);
        cph_d = (col_q >= CW'(K-1)) ? phase_step(cph_q, eff_stride) : 2'd0;
      end
    end
  end

  // Row K-1 is the incoming pixel; older rows come from progressively deeper lines.
  genvar gi, gj;
  generate
    for (gi = 0; gi < K; gi++) begin : g_row
      if (gi == K-1) begin : g_new
        assign new_col[gi] = in_data;
      end else begin : g_old
        assign new_col[gi] = line_rd[K-2-gi];
      end
      for (gj = 0; gj < K; gj++) begin : g_col
        localparam int IDX = int'(win_slice(K, gi, gj));
        if (gj == K-1) begin : g_in
          assign win_d[gi][gj] = new_col[gi];
        end else begin : g_sh
          assign win_d[gi][gj] = win_q[gi][gj+1];
        end
        assign win_flat[IDX*PW +: PW] = win_d[gi][gj];
      end
    end

    for (gi = 0; gi < K-1; gi++) begin : g_line
      logic [PW-1:0] wr_data;
      if (gi == 0) begin : g_first
        assign wr_data = in_data;
      end else begin : g_chain
        assign wr_data = line_rd[gi-1];
      end
      // Reading at the next column keeps the registered read one cycle ahead of the accept.
      line_ram #(.DEPTH(MAX_COLS), .WIDTH(PW), .ADDR_W(AW)) u_line (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (col_q[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (col_d[AW-1:0]),
        .rd_data (line_rd[gi])
      );
    end
  endgenerate

  always_comb begin
    out_valid_d  = out_valid_q;
    out_window_d = out_window_q;
    frame_done_d = 1'b0;
    if (clr) begin
      out_valid_d  = 1'b0;
      out_window_d = '0;
    end else if (accept) begin
      out_valid_d  = emit;
      out_window_d = emit ? win_flat : '0;
      frame_done_d = col_wrap && row_wrap;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
      out_window_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      cph_q        <= '0;
      rph_q        <= '0;
      cols_q       <= '0;
      rows_q       <= '0;
      stride_q     <= STRIDE_DEFAULT;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      cph_q        <= cph_d;
      rph_q        <= rph_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      frame_done_q <= frame_done_d;
      if (accept && first) begin
        cols_q   <= cfg_cols;
        rows_q   <= cfg_rows;
        stride_q <= stride_norm(cfg_stride);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_q[r][c] <= '0;
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  assign out_window = out_window_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Randomised self-checking bench for window_line_buffer against a
// position-indexed image model with a queue of expected windows.
module tb_window_line_buffer;

  localparam int DW = 8;
  localparam int CH = 1;
  localparam int K  = 3;
  localparam int MC = 16;
  localparam int MR = 16;
  localparam int WW = K*K*CH*DW;

  logic          clk, rst_n, clr;
  logic [4:0]    cfg_cols, cfg_rows;
  logic [1:0]    cfg_stride;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [WW-1:0] out_window;
  logic          out_valid, out_ready, frame_done;

  window_line_buffer #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .K(K), .MAX_COLS(MC), .MAX_ROWS(MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .cfg_cols   (cfg_cols),
    .cfg_rows   (cfg_rows),
    .cfg_stride (cfg_stride),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_window (out_window),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] img [MR][MC];
  int            m_n = 0, m_cols = 1, m_rows = 1, m_stride = 1;
  logic [WW-1:0] expq[$];
  logic [WW-1:0] win_log[$];
  int            fd_cnt = 0;
  bit            pend_acc = 0, pend_emit = 0, pend_last = 0, prev_stall = 0;
  logic [WW-1:0] prev_win = '0;
  int            rmode = 0, stall_left = 0;
  bit            stall_done = 0;

  always @(negedge clk) begin : mon
    int mc, mr;
    bit e;
    logic [WW-1:0] w;
    if (!rst_n) begin
      m_n = 0;
      expq.delete();
      pend_acc = 0;
      prev_stall = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_window", out_window, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_in_ready", in_ready, 1);
    end else begin
      check("in_ready", in_ready, out_ready || !out_valid);
      if (!out_valid) check("zero_window", out_window, 0);
      if (prev_stall) check("hold", {out_valid, out_window}, {1'b1, prev_win});
      if (pend_acc) begin
        check("latency_valid", out_valid, pend_emit);
        check("frame_done", frame_done, pend_last);
      end else begin
        check("frame_done_idle", frame_done, 0);
      end
      if (frame_done) fd_cnt++;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("extra_window", out_window, 0);
          check("extra_window_flag", 1, 0);
        end else begin
          w = expq.pop_front();
          check("window", out_window, w);
        end
        win_log.push_back(out_window);
      end
      prev_stall = out_valid && !out_ready;
      prev_win   = out_window;
      pend_acc   = 0;
      if (clr) begin
        m_n = 0;
        expq.delete();
        prev_stall = 0;
      end else if (in_valid && in_ready) begin
        if (m_n == 0) begin
          m_cols   = int'(cfg_cols);
          m_rows   = int'(cfg_rows);
          m_stride = (cfg_stride == 2'd0) ? 1 : int'(cfg_stride);
        end
        mc = m_n % m_cols;
        mr = m_n / m_cols;
        img[mr][mc] = in_data;
        e = (mc >= K-1) && (mr >= K-1) &&
            ((mc-(K-1)) % m_stride == 0) && ((mr-(K-1)) % m_stride == 0);
        if (e) begin
          w = '0;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              w[(i*K+j)*DW +: DW] = img[mr-K+1+i][mc-K+1+j];
          expq.push_back(w);
        end
        pend_acc  = 1;
        pend_emit = e;
        pend_last = (m_n == m_cols*m_rows - 1);
        m_n = (m_n + 1) % (m_cols*m_rows);
      end
    end
  end

  // Output back-pressure: 0 always ready, 1 random, 2 five-cycle stall on first window
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        1: out_ready = ($urandom_range(3) != 0);
        2: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else if (!stall_done && out_valid) begin
            out_ready  = 1'b0;
            stall_left = 4;
            stall_done = 1;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic start_scn(input int mode);
    win_log.delete();
    fd_cnt     = 0;
    rmode      = mode;
    stall_done = 0;
    stall_left = 0;
  endtask

  task automatic send_frame(input int cols, input int rows, input int stride, input int base,
                            input bit rnd, input bit gaps, input int limit);
    int tot, waitc;
    bit acc;
    tot = cols * rows;
    if (limit < tot) tot = limit;
    cfg_cols   = 5'(cols);
    cfg_rows   = 5'(rows);
    cfg_stride = 2'(stride);
    for (int i = 0; i < tot; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = rnd ? DW'($urandom) : DW'(base + i);
      acc   = 0;
      waitc = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (!acc) begin
          waitc++;
          if (waitc > 200) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
          end
        end
      end
      // Mid-frame configuration changes must be ignored
      if (i == 0) begin
        cfg_cols   = 5'($urandom_range(1, 16));
        cfg_rows   = 5'($urandom_range(1, 16));
        cfg_stride = 2'($urandom);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    @(negedge clk);
    while ((out_valid || expq.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", (t < 100), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [WW-1:0] ew;
    logic [WW-1:0] gw;
    int k, cols, rows, s, nw;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_cols = 5'd8; cfg_rows = 5'd8; cfg_stride = 2'd1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 8x8, stride 1
    start_scn(0);
    send_frame(8, 8, 1, 0, 0, 0, 64);
    drain();
    check("s1_count", win_log.size(), 36);
    check("s1_frame_done", fd_cnt, 1);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        ew[(i*K+j)*DW +: DW] = DW'(i*8 + j);
    check("s1_first_window", win_log[0], ew);
    $display("scenario 8x8 stride1: %0d windows, %0d frame_done", win_log.size(), fd_cnt);

    // 8x8, stride 2: centres at 1,3,5
    start_scn(0);
    send_frame(8, 8, 2, 0, 0, 0, 64);
    drain();
    check("s2_count", win_log.size(), 9);
    k = 0;
    for (int r = 1; r <= 5; r += 2)
      for (int c = 1; c <= 5; c += 2) begin
        gw = win_log[k];
        check("s2_centre", gw[4*DW +: DW], r*8 + c);
        k++;
      end
    $display("scenario 8x8 stride2: %0d windows", win_log.size());

    // Stall after first window
    start_scn(2);
    send_frame(8, 8, 1, 0, 0, 0, 64);
    drain();
    check("s3_count", win_log.size(), 36);
    check("s3_frame_done", fd_cnt, 1);
    $display("scenario stall: %0d windows", win_log.size());

    // Frame narrower than kernel
    start_scn(0);
    send_frame(2, 8, 1, 0, 1, 0, 16);
    drain();
    check("s4_count", win_log.size(), 0);
    check("s4_frame_done", fd_cnt, 1);
    $display("scenario 2x8: %0d windows, %0d frame_done", win_log.size(), fd_cnt);

    // Back-to-back 5x5 frames
    start_scn(0);
    send_frame(5, 5, 1, 0, 0, 0, 25);
    send_frame(5, 5, 1, 100, 0, 0, 25);
    drain();
    check("s5_count", win_log.size(), 18);
    check("s5_frame_done", fd_cnt, 2);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        ew[(i*K+j)*DW +: DW] = DW'(100 + i*5 + j);
    check("s5_second_first", win_log[9], ew);
    $display("scenario back-to-back: %0d windows, %0d frame_done", win_log.size(), fd_cnt);

    // Reset at pixel 20, then a fresh frame
    start_scn(0);
    send_frame(8, 8, 1, 0, 0, 0, 20);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("s6_no_stale", out_valid, 0);
    start_scn(0);
    send_frame(8, 8, 1, 50, 0, 0, 64);
    drain();
    check("s6_count", win_log.size(), 36);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        ew[(i*K+j)*DW +: DW] = DW'(50 + i*8 + j);
    check("s6_first_window", win_log[0], ew);
    $display("scenario reset mid-frame: %0d windows", win_log.size());

    // Clear mid-frame with a simultaneous offered pixel
    start_scn(0);
    send_frame(6, 6, 1, 0, 1, 0, 17);
    clr = 1'b1; in_valid = 1'b1; in_data = DW'($urandom);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    check("s7_clr_valid", out_valid, 0);
    start_scn(0);
    send_frame(5, 5, 1, 0, 1, 1, 25);
    drain();
    check("s7_count", win_log.size(), 9);
    check("s7_frame_done", fd_cnt, 1);
    $display("scenario clr: %0d windows", win_log.size());

    // Random frames, random gaps and back-pressure
    for (int f = 0; f < 5; f++) begin
      start_scn(1);
      cols = $urandom_range(3, 8);
      rows = $urandom_range(3, 8);
      s    = $urandom_range(0, 3);
      send_frame(cols, rows, s, 0, 1, 1, 64);
      drain();
      if (s == 0) s = 1;
      nw = ((cols-K)/s + 1) * ((rows-K)/s + 1);
      check("rnd_count", win_log.size(), nw);
      check("rnd_frame_done", fd_cnt, 1);
      $display("random frame %0dx%0d stride %0d: %0d windows", cols, rows, s, win_log.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
